// File: rtl/fc_ctrl_pkg.sv
// Shared types and helpers for the fully-connected layer controller.
// State and accumulator-command encodings are fixed so the datapath can decode acc_op directly.
package fc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        OUT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        FIRST = 2'b01,
        ACC   = 2'b10
    } acc_op_e;

    // Address width for a memory of the given depth; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fc_layer_ctrl.sv
// Sequencer for one fully-connected layer: loads an N-element vector, then walks
// M rows of N-term dot products through a registered-read MAC datapath.
module fc_layer_ctrl
    import fc_ctrl_pkg::*;
#(
    parameter int M  = 4,
    parameter int N  = 4,
    parameter int XW = addr_width(N),
    parameter int WW = addr_width(M * N),
    parameter int BW = addr_width(M)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          x_wr_en,
    output logic [XW-1:0] x_addr,
    output logic [WW-1:0] w_addr,
    output logic [BW-1:0] b_addr,
    output logic [1:0]    acc_op,
    output logic          acc_last
);

    // k runs 0..N inclusive: N address issues plus one drain cycle for the read latency.
    localparam int            KW       = $clog2(N + 1);
    localparam logic [XW-1:0] X_LAST   = XW'(N - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(N);
    localparam logic [KW-1:0] K_ONE    = KW'(1);
    localparam logic [BW-1:0] ROW_LAST = BW'(M - 1);

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [BW-1:0] row_q, row_d;
    logic [XW-1:0] x_addr_q, x_addr_d;
    logic [WW-1:0] w_addr_q, w_addr_d;
    acc_op_e       acc_op_q, acc_op_d;
    logic          acc_last_q, acc_last_d;
    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    logic          s_fire;
    logic          m_fire;

    assign s_fire = s_valid & s_ready_q;
    assign m_fire = m_ready & m_valid_q;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        row_d    = row_q;
        x_addr_d = x_addr_q;
        w_addr_d = w_addr_q;
        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (s_fire) begin
                    if (x_addr_q == X_LAST) begin
                        x_addr_d = '0;
                        k_d      = '0;
                        state_d  = MAC;
                    end else begin
                        x_addr_d = x_addr_q + 1'b1;
                    end
                end
            end
            MAC: begin
                if (k_q == K_LAST) begin
                    state_d = OUT;
                end else begin
                    // w_addr keeps counting across rows, so row*N is never multiplied out.
                    k_d      = k_q + 1'b1;
                    w_addr_d = w_addr_q + 1'b1;
                    x_addr_d = (x_addr_q == X_LAST) ? '0 : x_addr_q + 1'b1;
                end
            end
            OUT: begin
                if (m_fire) begin
                    k_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d    = '0;
                        w_addr_d = '0;
                        state_d  = LOAD;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = MAC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered and glitch-free.
    always_comb begin
        s_ready_d  = (state_d == LOAD);
        m_valid_d  = (state_d == OUT);
        acc_op_d   = HOLD;
        acc_last_d = 1'b0;
        if (state_d == MAC) begin
            if (k_d == '0) begin
                acc_op_d = HOLD;
            end else if (k_d == K_ONE) begin
                acc_op_d = FIRST;
            end else begin
                acc_op_d = ACC;
            end
            acc_last_d = (k_d == K_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            row_q      <= '0;
            x_addr_q   <= '0;
            w_addr_q   <= '0;
            acc_op_q   <= HOLD;
            acc_last_q <= 1'b0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            row_q      <= row_d;
            x_addr_q   <= x_addr_d;
            w_addr_q   <= w_addr_d;
            acc_op_q   <= acc_op_d;
            acc_last_q <= acc_last_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign m_valid  = m_valid_q;
    assign x_wr_en  = s_fire;
    assign x_addr   = x_addr_q;
    assign w_addr   = w_addr_q;
    assign b_addr   = row_q;
    assign acc_op   = acc_op_q;
    assign acc_last = acc_last_q;

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Cycle-level checks of fc_layer_ctrl: a 4x4 instance for the main flow and a 1x1
// instance for the degenerate single-term row.
module tb_fc_layer_ctrl;
    import fc_ctrl_pkg::*;

    localparam int M = 4;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, s_valid, m_ready, s_ready, m_valid, x_wr_en, acc_last;
    logic [1:0] x_addr, b_addr, acc_op;
    logic [3:0] w_addr;

    logic       reset1, s_valid1, m_ready1, s_ready1, m_valid1, x_wr_en1, acc_last1;
    logic [0:0] x_addr1, w_addr1, b_addr1;
    logic [1:0] acc_op1;

    fc_layer_ctrl #(.M(M), .N(N)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .m_valid(m_valid), .m_ready(m_ready), .x_wr_en(x_wr_en), .x_addr(x_addr),
        .w_addr(w_addr), .b_addr(b_addr), .acc_op(acc_op), .acc_last(acc_last)
    );

    fc_layer_ctrl #(.M(1), .N(1)) dut1 (
        .clk(clk), .reset(reset1), .s_valid(s_valid1), .s_ready(s_ready1),
        .m_valid(m_valid1), .m_ready(m_ready1), .x_wr_en(x_wr_en1), .x_addr(x_addr1),
        .w_addr(w_addr1), .b_addr(b_addr1), .acc_op(acc_op1), .acc_last(acc_last1)
    );

    // Address fields set to -1 are not checked in that cycle.
    typedef struct {
        int         id;
        logic       s_ready;
        logic       m_valid;
        logic       x_wr_en;
        int         x_addr;
        int         w_addr;
        int         b_addr;
        logic [1:0] acc_op;
        logic       acc_last;
    } exp_t;

    typedef struct {
        logic sv;
        int   xa;
    } ld_t;

    exp_t exp_q[$];
    ld_t  ld_tab[6];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   cyc_no = 0;

    function automatic exp_t e_idle();
        exp_t e;
        e.id = 0; e.s_ready = 1'b0; e.m_valid = 1'b0; e.x_wr_en = 1'b0;
        e.x_addr = 0; e.w_addr = 0; e.b_addr = 0; e.acc_op = HOLD; e.acc_last = 1'b0;
        return e;
    endfunction

    function automatic exp_t e_load(input logic sv, input int xa);
        exp_t e = e_idle();
        e.s_ready = 1'b1;
        e.x_wr_en = sv;
        e.x_addr  = xa;
        return e;
    endfunction

    function automatic exp_t e_mac(input int r, input int k, input int n);
        exp_t e = e_idle();
        e.x_addr   = (k < n) ? k : -1;
        e.w_addr   = (k < n) ? r * n + k : -1;
        e.b_addr   = r;
        e.acc_op   = (k == 0) ? HOLD : ((k == 1) ? FIRST : ACC);
        e.acc_last = (k == n);
        return e;
    endfunction

    function automatic exp_t e_out(input int r, input int n, input int m);
        exp_t e = e_idle();
        e.m_valid = 1'b1;
        e.x_addr  = -1;
        e.w_addr  = (r < m - 1) ? (r + 1) * n : -1;
        e.b_addr  = r;
        return e;
    endfunction

    task automatic fail_if(input bit bad, input string name, input int id, input int got, input int want);
        if (bad) begin
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, id, got, want);
            n_err++;
        end
    endtask

    task automatic compare(input exp_t e, input logic sr, input logic mv, input logic wr,
                           input int xa, input int wa, input int ba,
                           input logic [1:0] op, input logic last);
        n_vec++;
        fail_if(sr !== e.s_ready, "s_ready", e.id, int'(sr), int'(e.s_ready));
        fail_if(mv !== e.m_valid, "m_valid", e.id, int'(mv), int'(e.m_valid));
        fail_if(wr !== e.x_wr_en, "x_wr_en", e.id, int'(wr), int'(e.x_wr_en));
        fail_if(e.x_addr >= 0 && xa != e.x_addr, "x_addr", e.id, xa, e.x_addr);
        fail_if(e.w_addr >= 0 && wa != e.w_addr, "w_addr", e.id, wa, e.w_addr);
        fail_if(ba != e.b_addr, "b_addr", e.id, ba, e.b_addr);
        fail_if(op !== e.acc_op, "acc_op", e.id, int'(op), int'(e.acc_op));
        fail_if(last !== e.acc_last, "acc_last", e.id, int'(last), int'(e.acc_last));
    endtask

    // One clock cycle on the 4x4 instance: drive inputs, queue the expectation, then check.
    task automatic cyc(input logic rst, input logic sv, input logic mr, input exp_t e);
        exp_t got_e;
        @(negedge clk);
        reset = rst; s_valid = sv; m_ready = mr;
        cyc_no++;
        e.id = cyc_no;
        exp_q.push_back(e);
        #1;
        got_e = exp_q.pop_front();
        compare(got_e, s_ready, m_valid, x_wr_en, int'(x_addr), int'(w_addr), int'(b_addr), acc_op, acc_last);
        if (m_valid && m_ready && !rst) $display("cycle %0d: row %0d result accepted", cyc_no, b_addr);
    endtask

    task automatic cyc1(input logic rst, input logic sv, input logic mr, input exp_t e);
        exp_t got_e;
        @(negedge clk);
        reset1 = rst; s_valid1 = sv; m_ready1 = mr;
        cyc_no++;
        e.id = cyc_no;
        exp_q.push_back(e);
        #1;
        got_e = exp_q.pop_front();
        compare(got_e, s_ready1, m_valid1, x_wr_en1, int'(x_addr1), int'(w_addr1), int'(b_addr1), acc_op1, acc_last1);
        if (m_valid1 && m_ready1 && !rst) $display("cycle %0d: 1x1 result accepted", cyc_no);
    endtask

    task automatic load_vector();
        for (int i = 0; i < N; i++) cyc(1'b0, 1'b1, 1'b0, e_load(1'b1, i));
    endtask

    task automatic do_rows(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            for (int k = 0; k <= N; k++) cyc(1'b0, 1'b0, 1'b0, e_mac(r, k, N));
            cyc(1'b0, 1'b0, 1'b1, e_out(r, N, M));
        end
    endtask

    initial begin
        ld_tab[0] = '{1'b1, 0};
        ld_tab[1] = '{1'b0, 1};
        ld_tab[2] = '{1'b1, 1};
        ld_tab[3] = '{1'b1, 2};
        ld_tab[4] = '{1'b0, 3};
        ld_tab[5] = '{1'b1, 3};

        reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        reset1 = 1'b1; s_valid1 = 1'b0; m_ready1 = 1'b0;

        // Three reset cycles, then the release cycle still shows IDLE.
        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0, e_idle());
        cyc(1'b1, 1'b0, 1'b0, e_idle());
        cyc(1'b0, 1'b0, 1'b1, e_idle());

        for (int i = 0; i < 6; i++) cyc(1'b0, ld_tab[i].sv, 1'b0, e_load(ld_tab[i].sv, ld_tab[i].xa));

        // Row 0 with s_valid and m_ready asserted throughout MAC: both must be ignored.
        for (int k = 0; k <= N; k++) cyc(1'b0, 1'b1, 1'b1, e_mac(0, k, N));
        repeat (5) cyc(1'b0, 1'b1, 1'b0, e_out(0, N, M));
        cyc(1'b0, 1'b0, 1'b1, e_out(0, N, M));
        do_rows(1, M - 1);

        // Second vector, back-to-back beats, must repeat the same sequence.
        load_vector();
        do_rows(0, M - 1);
        cyc(1'b0, 1'b0, 1'b0, e_load(1'b0, 0));

        // Third vector interrupted by reset during row 2 MAC.
        load_vector();
        do_rows(0, 1);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, e_mac(2, k, N));
        cyc(1'b1, 1'b0, 1'b0, e_mac(2, 3, N));
        cyc(1'b1, 1'b1, 1'b1, e_idle());
        cyc(1'b0, 1'b0, 1'b0, e_idle());
        load_vector();
        do_rows(0, 0);

        // Degenerate 1x1 layer: FIRST and acc_last land in the same cycle.
        cyc1(1'b1, 1'b0, 1'b0, e_idle());
        cyc1(1'b0, 1'b0, 1'b0, e_idle());
        cyc1(1'b0, 1'b0, 1'b0, e_load(1'b0, 0));
        cyc1(1'b0, 1'b1, 1'b0, e_load(1'b1, 0));
        cyc1(1'b0, 1'b0, 1'b0, e_mac(0, 0, 1));
        cyc1(1'b0, 1'b0, 1'b0, e_mac(0, 1, 1));
        cyc1(1'b0, 1'b0, 1'b0, e_out(0, 1, 1));
        cyc1(1'b0, 1'b0, 1'b1, e_out(0, 1, 1));
        cyc1(1'b0, 1'b0, 1'b0, e_load(1'b0, 0));
        cyc1(1'b0, 1'b1, 1'b0, e_load(1'b1, 0));
        cyc1(1'b0, 1'b0, 1'b0, e_mac(0, 0, 1));
        cyc1(1'b0, 1'b0, 1'b0, e_mac(0, 1, 1));
        cyc1(1'b1, 1'b0, 1'b0, e_out(0, 1, 1));
        cyc1(1'b0, 1'b0, 1'b1, e_idle());
        cyc1(1'b0, 1'b0, 1'b0, e_load(1'b0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
